io_bus_fanout: RTL and testbench
================================

IO_BUS_FANOUT -- requirements
Module: io_bus_fanout

Interface
REQ-001 SHALL have parameter BITS_PER_BUS, default 8, data width of every bus.
REQ-002 SHALL have parameter ADDR_BITS, default 8, CPU IO address width.
REQ-003 SHALL have parameter NR_OF_BUSSES_OUT, default 4, number of peripheral slots (1..16).
REQ-004 SHALL have parameter SLOT_SIZE_LOG2, default 4, log2 of addresses per slot.
REQ-005 SHALL have parameter BASE_ADDR, default 0, first address of slot 0.
REQ-006 SHALL have parameter TIMEOUT, default 15, max wait cycles for ack (1..255).
REQ-007 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-008 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-009 SHALL have port addr_in  in  ADDR_BITS  CPU IO address.
REQ-010 SHALL have port data_in  in  BITS_PER_BUS  CPU write data.
REQ-011 SHALL have port wr_in  in  1  CPU write request, sampled when busy low.
REQ-012 SHALL have port rd_in  in  1  CPU read request, sampled when busy low.
REQ-013 SHALL have port busy  out  1  transaction in flight; new requests ignored.
REQ-014 SHALL have port err  out  1  sticky error flag.
REQ-015 SHALL have port err_clr  in  1  synchronous clear of err.
REQ-016 SHALL have port addr_out  out  SLOT_SIZE_LOG2  slot-local offset, shared by all slots.
REQ-017 SHALL have port data_out  out  BITS_PER_BUS  latched write data, shared by all slots.
REQ-018 SHALL have port wr_out  out  NR_OF_BUSSES_OUT  one-hot per-slot write strobe.
REQ-019 SHALL have port rd_out  out  NR_OF_BUSSES_OUT  one-hot per-slot read strobe.
REQ-020 SHALL have port ack_in  in  NR_OF_BUSSES_OUT  per-slot completion.

Function
REQ-021 SHALL implement states IDLE, STROBE, WAIT.
REQ-022 In IDLE with wr_in or rd_in high, SHALL compute off = addr_in - BASE_ADDR and slot = off >> SLOT_SIZE_LOG2 at ADDR_BITS width.
REQ-023 Request with addr_in < BASE_ADDR or slot >= NR_OF_BUSSES_OUT SHALL set err next cycle, produce no strobe, and stay IDLE.
REQ-024 Valid request SHALL latch slot, off[SLOT_SIZE_LOG2-1:0] into addr_out, data_in into data_out (writes only), set busy, and enter STROBE.
REQ-025 wr_in and rd_in high together SHALL be treated as a write; read dropped, err unaffected.
REQ-026 In STROBE, exactly one bit of wr_out or rd_out SHALL be high for exactly one cycle (latency: strobe 1 cycle after request sample); next state WAIT.
REQ-027 In WAIT, ack_in[slot] high SHALL return to IDLE and clear busy on the following edge; ack_in of other slots ignored.
REQ-028 ack_in[slot] high during STROBE SHALL be honoured: go directly IDLE, busy clears next edge (zero-wait peripheral).
REQ-029 Wait counter SHALL reset to 0 on entering STROBE and increment each WAIT cycle; reaching TIMEOUT without ack SHALL set err and return IDLE.
REQ-030 wr_in/rd_in while busy high SHALL be ignored (no queueing).
REQ-031 addr_out and data_out SHALL hold their values from latch until next valid request.
REQ-032 err_clr high SHALL clear err unless a new error sets it same cycle (set wins).
REQ-033 wr_out and rd_out SHALL be zero in IDLE and WAIT.

Reset
REQ-034 rst low SHALL asynchronously force IDLE, busy=0, err=0, wr_out=0, rd_out=0, addr_out=0, data_out=0, counter=0.
REQ-035 rst low mid-transaction SHALL abort without strobe; first request after release starts cleanly.

Verification
REQ-036 Write addr_in=0x23, data_in=0xA5, defaults: wr_out=4'b0100 one cycle later for one cycle, addr_out=3, data_out=0xA5; ack_in[2] after 2 cycles -> busy low next edge.
REQ-037 Read addr_in=0x05, ack_in[0] asserted during STROBE: rd_out=4'b0001 one cycle, busy high exactly 2 cycles.
REQ-038 Write addr_in=0x40 (slot 4, out of range): no strobe, err=1 next cycle, busy stays 0; err_clr pulse -> err=0.
REQ-039 Read slot 1, no ack: err=1 and busy=0 after TIMEOUT=15 WAIT cycles; later ack_in[1] pulse has no effect.
REQ-040 wr_in and rd_in both high at 0x11: only wr_out[1] pulses; second request during busy ignored (no second strobe).
REQ-041 rst low during WAIT: all outputs zero immediately; after release, request to slot 3 behaves as REQ-036.

Source files
------------

// File: rtl/io_bus_fanout.sv
// io_bus_fanout: routes one CPU IO port onto a row of peripheral slots.
// Decodes the slot, pulses a one-hot strobe, then waits for that slot's ack.
module io_bus_fanout #(
    parameter int BITS_PER_BUS     = 8,
    parameter int ADDR_BITS        = 8,
    parameter int NR_OF_BUSSES_OUT = 4,
    parameter int SLOT_SIZE_LOG2   = 4,
    parameter int BASE_ADDR        = 0,
    parameter int TIMEOUT          = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_BITS-1:0]        addr_in,
    input  logic [BITS_PER_BUS-1:0]     data_in,
    input  logic                        wr_in,
    input  logic                        rd_in,
    output logic                        busy,
    output logic                        err,
    input  logic                        err_clr,
    output logic [SLOT_SIZE_LOG2-1:0]   addr_out,
    output logic [BITS_PER_BUS-1:0]     data_out,
    output logic [NR_OF_BUSSES_OUT-1:0] wr_out,
    output logic [NR_OF_BUSSES_OUT-1:0] rd_out,
    input  logic [NR_OF_BUSSES_OUT-1:0] ack_in
);

    localparam int SLOT_W = (NR_OF_BUSSES_OUT > 1) ? $clog2(NR_OF_BUSSES_OUT) : 1;
    localparam int CMP_W  = ADDR_BITS + 8;
    localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(BASE_ADDR);
    localparam logic [7:0]           CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                      r_state;
    logic [SLOT_W-1:0]           r_slot;
    logic [7:0]                  r_cnt;
    logic                        r_busy;
    logic                        r_err;
    logic [SLOT_SIZE_LOG2-1:0]   r_addr;
    logic [BITS_PER_BUS-1:0]     r_data;
    logic [NR_OF_BUSSES_OUT-1:0] r_wr;
    logic [NR_OF_BUSSES_OUT-1:0] r_rd;

    logic [ADDR_BITS-1:0]        w_off;
    logic [ADDR_BITS-1:0]        w_slot;
    logic [SLOT_W-1:0]           w_slot_idx;
    logic                        w_bad;
    logic                        w_req;
    logic                        w_ack;
    logic [NR_OF_BUSSES_OUT-1:0] w_onehot;

    assign w_off      = addr_in - BASE;
    assign w_slot     = w_off >> SLOT_SIZE_LOG2;
    assign w_slot_idx = w_slot[SLOT_W-1:0];
    assign w_bad      = (addr_in < BASE) ||
                        (CMP_W'(w_slot) >= CMP_W'(NR_OF_BUSSES_OUT));
    assign w_req      = (wr_in | rd_in) & ~r_busy & (r_state == IDLE);
    assign w_ack      = ack_in[r_slot];
    assign w_onehot   = NR_OF_BUSSES_OUT'(1) << w_slot_idx;

    // Transaction FSM with all outputs registered; a new error beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (err_clr) begin
                r_err <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (w_req) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_slot  <= w_slot_idx;
                            r_addr  <= w_off[SLOT_SIZE_LOG2-1:0];
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= STROBE;
                            if (wr_in) begin
                                r_data <= data_in;
                                r_wr   <= w_onehot;
                            end else begin
                                r_rd   <= w_onehot;
                            end
                        end
                    end
                end
                STROBE: begin
                    r_wr <= '0;
                    r_rd <= '0;
                    // zero-wait ack: busy drops on the IDLE edge that follows
                    if (w_ack) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_ack) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_wr    <= '0;
                    r_rd    <= '0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign err      = r_err;
    assign addr_out = r_addr;
    assign data_out = r_data;
    assign wr_out   = r_wr;
    assign rd_out   = r_rd;

endmodule

// File: tb/tb_io_bus_fanout.sv
// tb_io_bus_fanout: directed vectors for io_bus_fanout at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_bus_fanout;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr_in;
    logic [7:0] data_in;
    logic       wr_in;
    logic       rd_in;
    logic       busy;
    logic       err;
    logic       err_clr;
    logic [3:0] addr_out;
    logic [7:0] data_out;
    logic [3:0] wr_out;
    logic [3:0] rd_out;
    logic [3:0] ack_in;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wait;

    always #5 clk = ~clk;

    io_bus_fanout dut (
        .clk      (clk),
        .rst      (rst),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .wr_in    (wr_in),
        .rd_in    (rd_in),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr),
        .addr_out (addr_out),
        .data_out (data_out),
        .wr_out   (wr_out),
        .rd_out   (rd_out),
        .ack_in   (ack_in)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; addr_in = '0; data_in = '0;
        wr_in = 1'b0; rd_in = 1'b0; err_clr = 1'b0; ack_in = '0;
        nxt();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr", 32'(wr_out), 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        rst = 1'b1;

        // write to slot 2, ack after two WAIT cycles
        nxt(); addr_in = 8'h23; data_in = 8'hA5; wr_in = 1'b1;
        nxt();
        chk("w_strobe", 32'(wr_out), 32'h4);
        chk("w_rd", 32'(rd_out), 32'h0);
        chk("w_addr", 32'(addr_out), 32'h3);
        chk("w_data", 32'(data_out), 32'hA5);
        chk("w_busy", 32'(busy), 32'd1);
        wr_in = 1'b0; data_in = 8'hFF;
        nxt();
        chk("w_one_cyc", 32'(wr_out), 32'h0);
        chk("w_busy2", 32'(busy), 32'd1);
        ack_in = 4'b0001;
        nxt();
        chk("w_other_ack", 32'(busy), 32'd1);
        ack_in = 4'b0100;
        nxt();
        chk("w_done", 32'(busy), 32'd0);
        chk("w_hold_data", 32'(data_out), 32'hA5);
        ack_in = '0;

        // read slot 0, ack during strobe
        addr_in = 8'h05; rd_in = 1'b1;
        nxt();
        chk("r0_strobe", 32'(rd_out), 32'h1);
        chk("r0_wr", 32'(wr_out), 32'h0);
        chk("r0_addr", 32'(addr_out), 32'h5);
        chk("r0_data", 32'(data_out), 32'hA5);
        chk("r0_busy1", 32'(busy), 32'd1);
        rd_in = 1'b0; ack_in = 4'b0001;
        nxt();
        chk("r0_one_cyc", 32'(rd_out), 32'h0);
        chk("r0_busy2", 32'(busy), 32'd1);
        ack_in = '0;
        nxt();
        chk("r0_done", 32'(busy), 32'd0);

        // out-of-range slot
        addr_in = 8'h40; wr_in = 1'b1;
        nxt();
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_wr", 32'(wr_out), 32'h0);
        wr_in = 1'b0; err_clr = 1'b1;
        nxt();
        chk("oor_clr", 32'(err), 32'd0);

        // set beats clear in the same cycle
        addr_in = 8'h40; wr_in = 1'b1; err_clr = 1'b1;
        nxt();
        chk("set_wins", 32'(err), 32'd1);
        wr_in = 1'b0;
        nxt();
        chk("clr_after", 32'(err), 32'd0);
        err_clr = 1'b0;

        // read slot 1, never acked
        addr_in = 8'h10; rd_in = 1'b1;
        nxt();
        chk("to_strobe", 32'(rd_out), 32'h2);
        rd_in = 1'b0;
        n_wait = 0;
        for (int i = 0; i < 40; i++) begin
            nxt();
            if (!busy) break;
            n_wait++;
        end
        chk("to_cycles", 32'(n_wait), 32'd15);
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        ack_in = 4'b0010;
        nxt();
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_rd", 32'(rd_out), 32'h0);
        chk("late_ack_err", 32'(err), 32'd1);
        ack_in = '0; err_clr = 1'b1;
        nxt();
        err_clr = 1'b0;
        chk("to_clr", 32'(err), 32'd0);

        // write+read together, then a request while busy
        addr_in = 8'h11; data_in = 8'h3C; wr_in = 1'b1; rd_in = 1'b1;
        nxt();
        chk("both_wr", 32'(wr_out), 32'h2);
        chk("both_rd", 32'(rd_out), 32'h0);
        chk("both_err", 32'(err), 32'd0);
        chk("both_data", 32'(data_out), 32'h3C);
        chk("both_addr", 32'(addr_out), 32'h1);
        addr_in = 8'h30; data_in = 8'h77; rd_in = 1'b0;
        nxt();
        chk("ign_wr", 32'(wr_out), 32'h0);
        chk("ign_addr", 32'(addr_out), 32'h1);
        chk("ign_data", 32'(data_out), 32'h3C);
        chk("ign_busy", 32'(busy), 32'd1);
        wr_in = 1'b0; ack_in = 4'b0010;
        nxt();
        chk("both_done", 32'(busy), 32'd0);
        chk("both_no_2nd", 32'(wr_out), 32'h0);
        ack_in = '0;

        // reset during WAIT
        addr_in = 8'h27; rd_in = 1'b1;
        nxt();
        chk("ar_strobe", 32'(rd_out), 32'h4);
        chk("ar_addr", 32'(addr_out), 32'h7);
        rd_in = 1'b0;
        nxt();
        chk("ar_wait", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_addr0", 32'(addr_out), 32'h0);
        chk("ar_data0", 32'(data_out), 32'h0);
        chk("ar_wr0", 32'(wr_out), 32'h0);
        chk("ar_rd0", 32'(rd_out), 32'h0);
        nxt();
        rst = 1'b1; addr_in = 8'h35; data_in = 8'h5A; wr_in = 1'b1;
        nxt();
        chk("s3_strobe", 32'(wr_out), 32'h8);
        chk("s3_addr", 32'(addr_out), 32'h5);
        chk("s3_data", 32'(data_out), 32'h5A);
        chk("s3_busy", 32'(busy), 32'd1);
        wr_in = 1'b0;
        nxt();
        chk("s3_one_cyc", 32'(wr_out), 32'h0);
        ack_in = 4'b1000;
        nxt();
        chk("s3_done", 32'(busy), 32'd0);
        ack_in = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
